sample_fifo: RTL and testbench

Parametrised single-clock FIFO for audio sample streams, the generalised successor of the fixed 8-bit × 16 sample buffer. Provides write/read pointer management, full/empty and threshold flags, a fill-level count, and sticky overflow/underflow error flags around an inferred register array. Sits between the codec interface and the effect processing chain.

---
 rtl/sample_fifo_if.sv | 32 +++
 rtl/sample_fifo.sv | 99 +++++++++
 tb/tb_sample_fifo.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_fifo_if.sv
// Handshake bundle between a sample producer/consumer and sample_fifo.
// The FIFO side uses the slave modport; the stream side uses master.
interface sample_fifo_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic              clr_err;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, din, rd_en, clr_err,
    input  dout, dout_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en, clr_err,
    output dout, dout_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );
endinterface

// File: rtl/sample_fifo.sv
// Single-clock audio sample FIFO with level, threshold flags and sticky errors.
// Define SAMPLE_FIFO_FWFT_EN for a first-word-fall-through read port.
module sample_fifo #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  sample_fifo_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] AF_LEVEL = (ADDR_W + 1)'(DEPTH - AF_MARGIN);
  localparam logic [ADDR_W:0] AE_LEVEL = (ADDR_W + 1)'(AE_MARGIN);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]   rptr_q, rptr_d;
  logic [ADDR_W:0]   level;
  logic              full, empty;
  logic              wr_acc, rd_acc;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  // Flags come only from registered pointers; the extra MSB tells full from empty.
  assign level  = wptr_q - rptr_q;
  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                  (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);

  assign wr_acc = bus.wr_en && !full;
  assign rd_acc = bus.rd_en && !empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    if (wr_acc) wptr_d = wptr_q + 1'b1;
    if (rd_acc) rptr_d = rptr_q + 1'b1;
    if (bus.clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    // An error in the same cycle as clr_err must survive the clear.
    if (bus.wr_en && full)  ovf_d = 1'b1;
    if (bus.rd_en && empty) unf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q[ADDR_W-1:0]] <= bus.din;
  end

`ifdef SAMPLE_FIFO_FWFT_EN
  assign bus.dout       = mem_q[rptr_q[ADDR_W-1:0]];
  assign bus.dout_valid = !empty;
`else
  logic [DATA_W-1:0] dout_q;
  logic              dout_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= rd_acc;
      if (rd_acc) dout_q <= mem_q[rptr_q[ADDR_W-1:0]];
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
`endif

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.level        = level;
  assign bus.almost_full  = (level >= AF_LEVEL);
  assign bus.almost_empty = (level <= AE_LEVEL);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_sample_fifo.sv
// Self-checking bench for sample_fifo: a queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_sample_fifo;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 4;
  localparam int DEPTH     = 16;
  localparam int AF_MARGIN = 2;
  localparam int AE_MARGIN = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   ck_en    = 1'b0;

  sample_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

  sample_fifo #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .AF_MARGIN(AF_MARGIN), .AE_MARGIN(AE_MARGIN)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if.slave)
  );

  always #5 clk = ~clk;

  // Reference model: contents as a queue, errors as booleans.
  logic [DATA_W-1:0] mq [$];
  logic [DATA_W-1:0] m_dout  = '0;
  bit                m_valid = 1'b0;
  bit                m_ovf   = 1'b0;
  bit                m_unf   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  initial begin
    bit was_full, was_empty, rd_ok, wr_ok;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
      end else begin
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        rd_ok     = bus_if.rd_en && !was_empty;
        wr_ok     = bus_if.wr_en && !was_full;
        m_valid   = rd_ok;
        if (rd_ok) m_dout = mq.pop_front();
        if (wr_ok) mq.push_back(bus_if.din);
        if (bus_if.clr_err) begin
          m_ovf = 1'b0;
          m_unf = 1'b0;
        end
        if (bus_if.wr_en && was_full)  m_ovf = 1'b1;
        if (bus_if.rd_en && was_empty) m_unf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    int lvl;
    if (ck_en) begin
      lvl = mq.size();
      chk("level", 32'(bus_if.level), lvl);
      chk("empty", bus_if.empty, lvl == 0);
      chk("full", bus_if.full, lvl == DEPTH);
      chk("almost_full", bus_if.almost_full, (DEPTH - lvl) <= AF_MARGIN);
      chk("almost_empty", bus_if.almost_empty, lvl <= AE_MARGIN);
      chk("overflow", bus_if.overflow, m_ovf);
      chk("underflow", bus_if.underflow, m_unf);
`ifdef SAMPLE_FIFO_FWFT_EN
      chk("dout_valid", bus_if.dout_valid, lvl != 0);
      if (lvl != 0) chk("dout", 32'(bus_if.dout), 32'(mq[0]));
`else
      chk("dout_valid", bus_if.dout_valid, m_valid);
      chk("dout", 32'(bus_if.dout), 32'(m_dout));
`endif
    end
  end

  task automatic cyc(input bit w, input logic [DATA_W-1:0] d, input bit r, input bit c);
    bus_if.wr_en   = w;
    bus_if.din     = d;
    bus_if.rd_en   = r;
    bus_if.clr_err = c;
    @(posedge clk);
    #1;
    bus_if.wr_en   = 1'b0;
    bus_if.rd_en   = 1'b0;
    bus_if.clr_err = 1'b0;
  endtask

  // Read one word and check it against a literal in either read-port mode.
  task automatic read_expect(input string name, input logic [DATA_W-1:0] exp);
`ifdef SAMPLE_FIFO_FWFT_EN
    chk(name, 32'(bus_if.dout), 32'(exp));
    cyc(1'b0, '0, 1'b1, 1'b0);
`else
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk(name, 32'(bus_if.dout), 32'(exp));
`endif
  endtask

  task automatic reset_literals(input string tag);
    chk({tag, "_empty"}, bus_if.empty, 1);
    chk({tag, "_full"}, bus_if.full, 0);
    chk({tag, "_level"}, 32'(bus_if.level), 0);
    chk({tag, "_almost_empty"}, bus_if.almost_empty, 1);
    chk({tag, "_almost_full"}, bus_if.almost_full, 0);
    chk({tag, "_overflow"}, bus_if.overflow, 0);
    chk({tag, "_underflow"}, bus_if.underflow, 0);
    chk({tag, "_dout_valid"}, bus_if.dout_valid, 0);
`ifndef SAMPLE_FIFO_FWFT_EN
    chk({tag, "_dout"}, 32'(bus_if.dout), 0);
`endif
  endtask

  initial begin
    bus_if.wr_en   = 1'b0;
    bus_if.rd_en   = 1'b0;
    bus_if.clr_err = 1'b0;
    bus_if.din     = '0;
    #1;
    reset_literals("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ck_en = 1'b1;

    // Fill with 0x0001..0x0010
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(1'b1, DATA_W'(i), 1'b0, 1'b0);
      $display("write 0x%04h level=%0d af=%0b", i, bus_if.level, bus_if.almost_full);
      if (i == 13) chk("af_at_13", bus_if.almost_full, 0);
      if (i == 14) chk("af_at_14", bus_if.almost_full, 1);
    end
    chk("fill_full", bus_if.full, 1);
    chk("fill_level", 32'(bus_if.level), 16);
    cyc(1'b1, 16'h0011, 1'b0, 1'b0);
    chk("ovf_17th", bus_if.overflow, 1);
    chk("level_17th", 32'(bus_if.level), 16);

    // Sticky clear, then clear racing an overflow
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("clr_err_alone", bus_if.overflow, 0);
    cyc(1'b1, 16'h0099, 1'b0, 1'b1);
    chk("clr_vs_ovf", bus_if.overflow, 1);
    cyc(1'b0, '0, 1'b0, 1'b1);

    // Drain in order
    for (int i = 1; i <= DEPTH; i++) begin
      read_expect("drain_data", DATA_W'(i));
      $display("read  0x%04h level=%0d", bus_if.dout, bus_if.level);
    end
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("drain_empty", bus_if.empty, 1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("unf_extra", bus_if.underflow, 1);
    cyc(1'b0, '0, 1'b0, 1'b1);

    // Write and read together while full
    for (int i = 1; i <= DEPTH; i++) cyc(1'b1, DATA_W'(16'h0100 + i), 1'b0, 1'b0);
`ifdef SAMPLE_FIFO_FWFT_EN
    chk("full_both_dout", 32'(bus_if.dout), 32'h0101);
`endif
    cyc(1'b1, 16'h0555, 1'b1, 1'b0);
    $display("full+rw level=%0d ovf=%0b", bus_if.level, bus_if.overflow);
    chk("full_both_level", 32'(bus_if.level), 15);
    chk("full_both_ovf", bus_if.overflow, 1);
`ifndef SAMPLE_FIFO_FWFT_EN
    chk("full_both_dout", 32'(bus_if.dout), 32'h0101);
`endif
    for (int i = 2; i <= DEPTH; i++) read_expect("full_both_drain", DATA_W'(16'h0100 + i));
    cyc(1'b0, '0, 1'b0, 1'b1);

    // Write and read together while empty
    cyc(1'b1, 16'h0077, 1'b1, 1'b0);
    $display("empty+rw level=%0d unf=%0b", bus_if.level, bus_if.underflow);
    chk("empty_both_level", 32'(bus_if.level), 1);
    chk("empty_both_unf", bus_if.underflow, 1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    read_expect("empty_both_data", 16'h0077);

    // Level held at 5 under simultaneous traffic
    for (int i = 0; i < 5; i++) cyc(1'b1, DATA_W'(16'h0200 + i), 1'b0, 1'b0);
    cyc(1'b1, 16'h0205, 1'b1, 1'b0);
    $display("level5+rw level=%0d", bus_if.level);
    chk("level5_both", 32'(bus_if.level), 5);
    for (int i = 1; i <= 5; i++) read_expect("level5_drain", DATA_W'(16'h0200 + i));

    // Write 3 / read 3 rounds so both pointers wrap
    for (int k = 0; k < 12; k++) begin
      for (int j = 0; j < 3; j++) begin
        cyc(1'b1, DATA_W'(16'h1000 + k * 3 + j), 1'b0, 1'b0);
        chk("wrap_level_max", bus_if.level <= 3, 1);
      end
      for (int j = 0; j < 3; j++) begin
        read_expect("wrap_data", DATA_W'(16'h1000 + k * 3 + j));
        chk("wrap_level_max", bus_if.level <= 3, 1);
      end
      $display("wrap round %0d done level=%0d", k, bus_if.level);
    end

    // Mid-operation reset at level 7 with an error and a valid word pending
    cyc(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b1, DATA_W'(16'h0300 + i), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("pre_reset_level", 32'(bus_if.level), 7);
    chk("pre_reset_unf", bus_if.underflow, 1);
    #3;
    rst_n = 1'b0;
    #1;
    $display("async reset level=%0d empty=%0b", bus_if.level, bus_if.empty);
    reset_literals("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b1, 16'h0abc, 1'b0, 1'b0);
    read_expect("post_reset_data", 16'h0abc);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("post_reset_empty", bus_if.empty, 1);

    ck_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
